// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers and a four-state
// IDLE/LOAD/CNT/INT sequencer that produces a maskable interrupt flag.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic       enable;
  logic [1:0] mode;
  assign enable = ctrl[0];
  assign mode   = ctrl[2:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ctrl   <= 4'b0;
      preset <= 32'b0;
      count  <= 32'b0;
      flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enable) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // Terminal count of 0 or 1 both end here, so PRESET=0 acts as 1 and COUNT never wraps.
            count <= 32'b0;
            flag  <= 1'b1;
            state <= INT;
          end
        end
        INT: begin
          if (mode == 2'b01) begin
            flag  <= 1'b0;
            state <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a software CTRL write overrides the FSM's Enable/flag update.
      if (WE && Addr == 2'd0) begin
        ctrl <= Din[3:0];
        flag <= 1'b0;
      end
      if (WE && Addr == 2'd1) preset <= Din;
    end
  end

  always_comb begin
    Dout = 32'b0;
    case (Addr)
      2'd0:    Dout = {28'b0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'b0;
    endcase
  end

  assign IRQ = flag & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload, mask, disable/restart,
// PRESET edge cases and asynchronous reset mid-count.
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int fails  = 0;

  timer_counter dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  // All tasks start and end 1 ns after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; Din = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0; Din = 32'd0; Addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    #12;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin
        $display("FAIL reset_reg%0d: got %0h expected 0", a, d); fails++;
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", IRQ); fails++; end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick(3);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd0) begin $display("FAIL idle_after_reset: count %0d expected 0", d); fails++; end
  endtask

  task automatic test_one_shot;
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);           // edge 0
    tick(1);                   // edge 1: LOAD
    for (int e = 2; e <= 6; e++) begin
      tick(1);
      rd(2'd2, d);
      checks++;
      if (d !== 32'(7 - e) || IRQ !== 1'b0) begin
        $display("FAIL oneshot_count_e%0d: count %0d irq %b expected %0d irq 0", e, d, IRQ, 7 - e); fails++;
      end
    end
    tick(1);                   // edge 7
    rd(2'd2, d);
    checks++;
    if (IRQ !== 1'b1 || d !== 32'd0) begin
      $display("FAIL oneshot_irq: irq %b count %0d expected irq 1 count 0", IRQ, d); fails++;
    end
    tick(2);
    rd(2'd0, d);
    checks++;
    if (d !== 32'h8 || IRQ !== 1'b1) begin
      $display("FAIL oneshot_disabled: ctrl %0h irq %b expected ctrl 8 irq 1", d, IRQ); fails++;
    end
    wr(2'd0, 32'h8);
    checks++;
    if (IRQ !== 1'b0) begin $display("FAIL oneshot_ack: irq %b expected 0", IRQ); fails++; end
  endtask

  task automatic test_auto_reload;
    logic [31:0] d;
    logic        exp_irq;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);           // edge 0
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      exp_irq = (e == 5 || e == 10 || e == 15);
      rd(2'd2, d);
      checks++;
      if (IRQ !== exp_irq || d > 32'd3) begin
        $display("FAIL reload_e%0d: irq %b count %0d expected irq %b count<=3", e, IRQ, d, exp_irq); fails++;
      end
    end
    wr(2'd0, 32'h0);
    tick(4);
  endtask

  task automatic test_mask;
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);           // edge 0, IM=0
    tick(7);
    rd(2'd2, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'd0) begin
      $display("FAIL mask_irq: irq %b count %0d expected irq 0 count 0", IRQ, d); fails++;
    end
    wr(2'd0, 32'h8);
    tick(2);
    checks++;
    if (IRQ !== 1'b0) begin $display("FAIL mask_unmask: irq %b expected 0", IRQ); fails++; end
  endtask

  task automatic test_disable_restart;
    logic [31:0] d;
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);           // edge 0
    tick(5);                   // edge 5: count 7
    rd(2'd2, d);
    checks++;
    if (d !== 32'd7) begin $display("FAIL dis_pre: count %0d expected 7", d); fails++; end
    wr(2'd0, 32'h0);           // edge 6: last decrement to 6
    tick(3);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd6) begin $display("FAIL dis_hold: count %0d expected 6", d); fails++; end
    wr(2'd0, 32'h1);           // edge j
    tick(1);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd6) begin $display("FAIL dis_load_edge: count %0d expected 6", d); fails++; end
    tick(1);
    rd(2'd2, d);
    checks++;
    if (d !== 32'd10) begin $display("FAIL dis_restart: count %0d expected 10", d); fails++; end
    wr(2'd0, 32'h0);
    tick(3);
  endtask

  task automatic test_edge_cases;
    logic [31:0] d;
    // PRESET rewrite during CNT
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);           // edge 0
    tick(2);                   // edge 2: count 4
    wr(2'd1, 32'd9);           // edge 3: count 3
    rd(2'd2, d);
    checks++;
    if (d !== 32'd3) begin $display("FAIL preset_mid_cnt: count %0d expected 3", d); fails++; end
    tick(2);                   // edge 5: count 1
    rd(2'd2, d);
    checks++;
    if (d !== 32'd1 || IRQ !== 1'b0) begin
      $display("FAIL preset_mid_cnt_e5: count %0d irq %b expected 1 irq 0", d, IRQ); fails++;
    end
    tick(1);
    checks++;
    if (IRQ !== 1'b1) begin $display("FAIL preset_mid_cnt_irq: irq %b expected 1", IRQ); fails++; end
    tick(2);
    wr(2'd0, 32'h8);
    // PRESET = 0 behaves as 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);           // edge 0
    tick(2);
    rd(2'd2, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'd0) begin
      $display("FAIL preset0_e2: irq %b count %0d expected irq 0 count 0", IRQ, d); fails++;
    end
    tick(1);
    checks++;
    if (IRQ !== 1'b1) begin $display("FAIL preset0_irq: irq %b expected 1", IRQ); fails++; end
    tick(2);
    wr(2'd0, 32'h8);
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] d;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(3);
    #2 reset = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin $display("FAIL midreset_reg%0d: got %0h expected 0", a, d); fails++; end
    end
    checks++;
    if (IRQ !== 1'b0) begin $display("FAIL midreset_irq: irq %b expected 0", IRQ); fails++; end
    @(negedge clk);
    reset = 1'b1;
    wr(2'd1, 32'd7);           // first edge after release
    rd(2'd1, d);
    checks++;
    if (d !== 32'd7) begin $display("FAIL first_edge_write: preset %0d expected 7", d); fails++; end
    tick(10);
    rd(2'd2, d);
    checks++;
    if (IRQ !== 1'b0 || d !== 32'd0) begin
      $display("FAIL midreset_after: irq %b count %0d expected irq 0 count 0", IRQ, d); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mask();
    test_disable_restart();
    test_edge_cases();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
